// File: rtl/axi_dma_pkg.sv
// Shared types for the DMA burst path: AX/R/W descriptors and the request
// bundles exchanged between the burst splitter and the data mover.
package axi_dma_pkg;

  localparam int unsigned DefDataWidth   = 64;
  localparam int unsigned DefAddrWidth   = 64;
  localparam int unsigned DefIdWidth     = 6;
  localparam int unsigned DefStrbWidth   = DefDataWidth / 8;
  localparam int unsigned DefOffsetWidth = $clog2(DefStrbWidth);
  localparam int unsigned PageBytes      = 4096;
  localparam logic [1:0]  BurstIncr      = 2'b01;

  typedef enum logic [0:0] {
    SideIdle = 1'b0,
    SideBusy = 1'b1
  } side_state_e;

  typedef struct packed {
    logic [DefIdWidth-1:0]   id;
    logic                    last;
    logic [DefAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [3:0]              cache;
  } desc_ax_t;

  typedef struct packed {
    logic [DefOffsetWidth-1:0] offset;
    logic [DefOffsetWidth-1:0] tailer;
    logic [DefOffsetWidth-1:0] shift;
  } desc_r_t;

  typedef struct packed {
    logic [DefOffsetWidth-1:0] offset;
    logic [DefOffsetWidth-1:0] tailer;
    logic [7:0]                num_beats;
    logic                      is_single;
  } desc_w_t;

  typedef struct packed {
    logic [DefIdWidth-1:0]   id;
    logic [DefAddrWidth-1:0] src;
    logic [DefAddrWidth-1:0] dst;
    logic [DefAddrWidth-1:0] num_bytes;
    logic [3:0]              cache_src;
    logic [3:0]              cache_dst;
  } burst_req_t;

  typedef struct packed {
    desc_ax_t ar;
    desc_r_t  r;
  } read_req_t;

  typedef struct packed {
    desc_ax_t aw;
    desc_w_t  w;
  } write_req_t;

  // Byte rotation the data path applies to move source lanes onto destination lanes.
  function automatic logic [DefOffsetWidth-1:0] calc_shift(
    input logic [DefAddrWidth-1:0] src,
    input logic [DefAddrWidth-1:0] dst
  );
    logic [DefAddrWidth-1:0] diff;
    diff = src - dst;
    return diff[DefOffsetWidth-1:0];
  endfunction

endpackage

// File: rtl/axi_dma_burst_side.sv
// One side (read or write) of the burst splitter: walks an address range and
// emits registered INCR bursts clipped to 4 KiB pages and MaxBeats beats.
module axi_dma_burst_side
  import axi_dma_pkg::*;
#(
  parameter int unsigned AddrWidth   = DefAddrWidth,
  parameter int unsigned OffsetWidth = DefOffsetWidth,
  parameter int unsigned MaxBeats    = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [AddrWidth-1:0]   num_bytes_i,
  output logic                   idle_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [AddrWidth-1:0]   addr_o,
  output logic [7:0]             len_o,
  output logic [OffsetWidth-1:0] offset_o,
  output logic [OffsetWidth-1:0] tailer_o,
  output logic                   last_o
);

  localparam int unsigned CW = AddrWidth + 1;
  localparam logic [CW-1:0] PageBytesW    = CW'(PageBytes);
  localparam logic [CW-1:0] MaxBurstBytes = CW'(MaxBeats * (2 ** OffsetWidth));

  side_state_e state_q, state_d;
  // addr_q/rem_q describe what is left after the burst currently on the outputs
  logic [AddrWidth-1:0]   addr_q, addr_d, rem_q, rem_d;
  logic [AddrWidth-1:0]   burst_addr_q, burst_addr_d;
  logic [7:0]             len_q, len_d;
  logic [OffsetWidth-1:0] offset_q, offset_d, tailer_q, tailer_d;
  logic                   last_q, last_d;

  logic [AddrWidth-1:0] cur_addr_s, cur_rem_s;
  logic [CW-1:0]        off_s, to4k_s, tolen_s, rem_ext_s, clip_s, bytes_s, end_s, span_s;
  logic [7:0]           len_s;
  logic                 last_s, issue_s;

  // Size of the burst starting at the current walk position
  always_comb begin
    cur_addr_s = (state_q == SideIdle) ? addr_i : addr_q;
    cur_rem_s  = (state_q == SideIdle) ? num_bytes_i : rem_q;
    off_s      = CW'(cur_addr_s[OffsetWidth-1:0]);
    to4k_s     = PageBytesW - CW'(cur_addr_s[11:0]);
    tolen_s    = MaxBurstBytes - off_s;
    rem_ext_s  = CW'(cur_rem_s);
    clip_s     = (to4k_s < tolen_s) ? to4k_s : tolen_s;
    bytes_s    = (rem_ext_s < clip_s) ? rem_ext_s : clip_s;
    end_s      = off_s + bytes_s;
    span_s     = end_s - CW'(1);
    len_s      = 8'(span_s >> OffsetWidth);
    last_s     = (bytes_s == rem_ext_s);
  end

  // Next state: issue a burst on load or on a non-final handshake
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    burst_addr_d = burst_addr_q;
    len_d        = len_q;
    offset_d     = offset_q;
    tailer_d     = tailer_q;
    last_d       = last_q;
    issue_s      = 1'b0;
    case (state_q)
      SideIdle: begin
        if (load_i && (num_bytes_i != '0)) begin
          issue_s = 1'b1;
          state_d = SideBusy;
        end else begin
          state_d = SideIdle;
        end
      end
      SideBusy: begin
        if (ready_i && last_q) begin
          state_d = SideIdle;
        end else if (ready_i) begin
          issue_s = 1'b1;
        end else begin
          state_d = SideBusy;
        end
      end
      default: state_d = SideIdle;
    endcase
    if (issue_s) begin
      burst_addr_d = cur_addr_s;
      len_d        = len_s;
      offset_d     = off_s[OffsetWidth-1:0];
      tailer_d     = end_s[OffsetWidth-1:0];
      last_d       = last_s;
      addr_d       = cur_addr_s + bytes_s[AddrWidth-1:0];
      rem_d        = cur_rem_s - bytes_s[AddrWidth-1:0];
    end else begin
      addr_d = addr_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= SideIdle;
      addr_q       <= '0;
      rem_q        <= '0;
      burst_addr_q <= '0;
      len_q        <= 8'd0;
      offset_q     <= '0;
      tailer_q     <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      burst_addr_q <= burst_addr_d;
      len_q        <= len_d;
      offset_q     <= offset_d;
      tailer_q     <= tailer_d;
      last_q       <= last_d;
    end
  end

  assign idle_o   = (state_q == SideIdle);
  assign valid_o  = (state_q == SideBusy);
  assign addr_o   = burst_addr_q;
  assign len_o    = len_q;
  assign offset_o = offset_q;
  assign tailer_o = tailer_q;
  assign last_o   = last_q;

endmodule

// File: rtl/axi_dma_burst_splitter.sv
// Splits a 1D DMA transfer into independent read and write INCR burst streams
// for the data mover, with per-transfer id/cache/shift latched at accept.
module axi_dma_burst_splitter
  import axi_dma_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned IdWidth   = DefIdWidth,
  parameter int unsigned MaxBeats  = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  burst_req_t burst_req_i,
  input  logic       valid_i,
  output logic       ready_o,
  output read_req_t  read_req_o,
  output logic       r_valid_o,
  input  logic       r_ready_i,
  output write_req_t write_req_o,
  output logic       w_valid_o,
  input  logic       w_ready_i,
  output logic       idle_o
);

  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned OffsetWidth = $clog2(StrbWidth);

  if ((DataWidth != DefDataWidth) || (AddrWidth != DefAddrWidth) || (IdWidth != DefIdWidth)) begin : g_width_check
    $error("axi_dma_burst_splitter: widths must match the axi_dma_pkg types");
  end
  if ((MaxBeats == 0) || (MaxBeats > 256) || ((MaxBeats & (MaxBeats - 1)) != 0)) begin : g_beats_check
    $error("axi_dma_burst_splitter: MaxBeats must be a power of two <= 256");
  end

  logic                   accept_s, r_idle_s, w_idle_s;
  logic [AddrWidth-1:0]   r_addr_s, w_addr_s;
  logic [7:0]             r_len_s, w_len_s;
  logic [OffsetWidth-1:0] r_off_s, r_tail_s, w_off_s, w_tail_s;
  logic                   r_last_s, w_last_s;

  logic [IdWidth-1:0]     id_q, id_d;
  logic [3:0]             cache_src_q, cache_src_d, cache_dst_q, cache_dst_d;
  logic [OffsetWidth-1:0] shift_q, shift_d;

  assign ready_o  = r_idle_s & w_idle_s;
  assign idle_o   = r_idle_s & w_idle_s;
  assign accept_s = valid_i & ready_o;

  axi_dma_burst_side #(
    .AddrWidth  (AddrWidth),
    .OffsetWidth(OffsetWidth),
    .MaxBeats   (MaxBeats)
  ) i_read_side (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept_s),
    .addr_i     (burst_req_i.src),
    .num_bytes_i(burst_req_i.num_bytes),
    .idle_o     (r_idle_s),
    .valid_o    (r_valid_o),
    .ready_i    (r_ready_i),
    .addr_o     (r_addr_s),
    .len_o      (r_len_s),
    .offset_o   (r_off_s),
    .tailer_o   (r_tail_s),
    .last_o     (r_last_s)
  );

  axi_dma_burst_side #(
    .AddrWidth  (AddrWidth),
    .OffsetWidth(OffsetWidth),
    .MaxBeats   (MaxBeats)
  ) i_write_side (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept_s),
    .addr_i     (burst_req_i.dst),
    .num_bytes_i(burst_req_i.num_bytes),
    .idle_o     (w_idle_s),
    .valid_o    (w_valid_o),
    .ready_i    (w_ready_i),
    .addr_o     (w_addr_s),
    .len_o      (w_len_s),
    .offset_o   (w_off_s),
    .tailer_o   (w_tail_s),
    .last_o     (w_last_s)
  );

  // Per-transfer attributes captured on accept
  always_comb begin
    if (accept_s) begin
      id_d        = burst_req_i.id;
      cache_src_d = burst_req_i.cache_src;
      cache_dst_d = burst_req_i.cache_dst;
      shift_d     = calc_shift(burst_req_i.src, burst_req_i.dst);
    end else begin
      id_d        = id_q;
      cache_src_d = cache_src_q;
      cache_dst_d = cache_dst_q;
      shift_d     = shift_q;
    end
  end

  // Transfer attribute registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q        <= '0;
      cache_src_q <= 4'd0;
      cache_dst_q <= 4'd0;
      shift_q     <= '0;
    end else begin
      id_q        <= id_d;
      cache_src_q <= cache_src_d;
      cache_dst_q <= cache_dst_d;
      shift_q     <= shift_d;
    end
  end

  // Descriptor packing; constant fields are gated by valid so reset payload is all-zero
  always_comb begin
    read_req_o          = '0;
    read_req_o.ar.id    = id_q;
    read_req_o.ar.last  = r_last_s;
    read_req_o.ar.addr  = r_addr_s;
    read_req_o.ar.len   = r_len_s;
    read_req_o.ar.size  = r_valid_o ? 3'(OffsetWidth) : 3'd0;
    read_req_o.ar.burst = r_valid_o ? BurstIncr : 2'b00;
    read_req_o.ar.cache = cache_src_q;
    read_req_o.r.offset = r_off_s;
    read_req_o.r.tailer = r_tail_s;
    read_req_o.r.shift  = shift_q;

    write_req_o             = '0;
    write_req_o.aw.id       = id_q;
    write_req_o.aw.last     = w_last_s;
    write_req_o.aw.addr     = w_addr_s;
    write_req_o.aw.len      = w_len_s;
    write_req_o.aw.size     = w_valid_o ? 3'(OffsetWidth) : 3'd0;
    write_req_o.aw.burst    = w_valid_o ? BurstIncr : 2'b00;
    write_req_o.aw.cache    = cache_dst_q;
    write_req_o.w.offset    = w_off_s;
    write_req_o.w.tailer    = w_tail_s;
    write_req_o.w.num_beats = w_len_s;
    write_req_o.w.is_single = w_valid_o & (w_len_s == 8'd0);
  end

endmodule

// File: tb/tb_axi_dma_burst_splitter.sv
// Directed bench for axi_dma_burst_splitter: a table of transfers with
// hand-computed bursts plus sequences for backpressure, zero length and reset.
module tb_axi_dma_burst_splitter;
  import axi_dma_pkg::*;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  off;
    logic [2:0]  tail;
    logic        last;
  } exp_b_t;

  typedef struct packed {
    logic [63:0]      src;
    logic [63:0]      dst;
    logic [63:0]      nbytes;
    logic [1:0]       nr;
    logic [1:0]       nw;
    exp_b_t [1:0]     r;
    exp_b_t [1:0]     w;
    logic [2:0]       shift;
  } vec_t;

  localparam int NumVec = 6;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  burst_req_t burst_req_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  read_req_t  read_req_o;
  logic       r_valid_o;
  logic       r_ready_i = 1'b1;
  write_req_t write_req_o;
  logic       w_valid_o;
  logic       w_ready_i = 1'b1;
  logic       idle_o;

  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs [NumVec];

  axi_dma_burst_splitter dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .burst_req_i(burst_req_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .read_req_o (read_req_o),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .write_req_o(write_req_o),
    .w_valid_o  (w_valid_o),
    .w_ready_i  (w_ready_i),
    .idle_o     (idle_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  function automatic exp_b_t mkb(input logic [63:0] a, input logic [7:0] l,
                                 input logic [2:0] o, input logic [2:0] t, input logic la);
    exp_b_t e;
    e.addr = a; e.len = l; e.off = o; e.tail = t; e.last = la;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic cmp_r(input int v, input int k, input exp_b_t e, input logic [2:0] sh,
                       input logic [5:0] id, input logic [3:0] cache);
    string p;
    p = $sformatf("v%0d r%0d", v, k);
    chk({p, " addr"},   read_req_o.ar.addr, e.addr);
    chk({p, " len"},    read_req_o.ar.len, 64'(e.len));
    chk({p, " offset"}, read_req_o.r.offset, 64'(e.off));
    chk({p, " tailer"}, read_req_o.r.tailer, 64'(e.tail));
    chk({p, " last"},   read_req_o.ar.last, 64'(e.last));
    chk({p, " shift"},  read_req_o.r.shift, 64'(sh));
    chk({p, " id"},     read_req_o.ar.id, 64'(id));
    chk({p, " cache"},  read_req_o.ar.cache, 64'(cache));
    chk({p, " size"},   read_req_o.ar.size, 64'd3);
    chk({p, " burst"},  read_req_o.ar.burst, 64'd1);
  endtask

  task automatic cmp_w(input int v, input int k, input exp_b_t e,
                       input logic [5:0] id, input logic [3:0] cache);
    string p;
    p = $sformatf("v%0d w%0d", v, k);
    chk({p, " addr"},      write_req_o.aw.addr, e.addr);
    chk({p, " len"},       write_req_o.aw.len, 64'(e.len));
    chk({p, " offset"},    write_req_o.w.offset, 64'(e.off));
    chk({p, " tailer"},    write_req_o.w.tailer, 64'(e.tail));
    chk({p, " last"},      write_req_o.aw.last, 64'(e.last));
    chk({p, " num_beats"}, write_req_o.w.num_beats, 64'(e.len));
    chk({p, " is_single"}, write_req_o.w.is_single, (e.len == 8'd0) ? 64'd1 : 64'd0);
    chk({p, " id"},        write_req_o.aw.id, 64'(id));
    chk({p, " cache"},     write_req_o.aw.cache, 64'(cache));
    chk({p, " size"},      write_req_o.aw.size, 64'd3);
  endtask

  task automatic send(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] n,
                      input logic [5:0] id, input logic [3:0] cs, input logic [3:0] cd);
    burst_req_i.id        = id;
    burst_req_i.src       = src;
    burst_req_i.dst       = dst;
    burst_req_i.num_bytes = n;
    burst_req_i.cache_src = cs;
    burst_req_i.cache_dst = cd;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic run_vec(input int v, input vec_t t);
    int ri, wi;
    bit done;
    logic [5:0] id;
    logic [3:0] cs, cd;
    id = 6'(v + 1);
    cs = 4'(v);
    cd = 4'(15 - v);
    r_ready_i = 1'b1;
    w_ready_i = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d ready before accept", v), ready_o, 64'd1);
    send(t.src, t.dst, t.nbytes, id, cs, cd);
    ri = 0; wi = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (r_valid_o) begin
        if (ri < int'(t.nr)) cmp_r(v, ri, t.r[ri], t.shift, id, cs);
        else chk($sformatf("v%0d extra r burst", v), 64'd1, 64'd0);
        ri++;
      end
      if (w_valid_o) begin
        if (wi < int'(t.nw)) cmp_w(v, wi, t.w[wi], id, cd);
        else chk($sformatf("v%0d extra w burst", v), 64'd1, 64'd0);
        wi++;
      end
      if (r_valid_o || w_valid_o) chk($sformatf("v%0d ready while busy", v), ready_o, 64'd0);
      if (!r_valid_o && !w_valid_o && ri >= int'(t.nr) && wi >= int'(t.nw)) done = 1'b1;
      if (!done) @(negedge clk);
    end
    chk($sformatf("v%0d completed in budget", v), 64'(done), 64'd1);
    chk($sformatf("v%0d r burst count", v), 64'(ri), 64'(t.nr));
    chk($sformatf("v%0d w burst count", v), 64'(wi), 64'(t.nw));
    chk($sformatf("v%0d idle after", v), idle_o, 64'd1);
    chk($sformatf("v%0d ready after", v), ready_o, 64'd1);
  endtask

  initial begin
    vecs[0] = '{src: 64'h1000, dst: 64'h2000, nbytes: 64'd64, nr: 2'd1, nw: 2'd1,
                r: {exp_b_t'('0), mkb(64'h1000, 8'd7, 3'd0, 3'd0, 1'b1)},
                w: {exp_b_t'('0), mkb(64'h2000, 8'd7, 3'd0, 3'd0, 1'b1)}, shift: 3'd0};
    vecs[1] = '{src: 64'h0FF8, dst: 64'h3000, nbytes: 64'd16, nr: 2'd2, nw: 2'd1,
                r: {mkb(64'h1000, 8'd0, 3'd0, 3'd0, 1'b1), mkb(64'h0FF8, 8'd0, 3'd0, 3'd0, 1'b0)},
                w: {exp_b_t'('0), mkb(64'h3000, 8'd1, 3'd0, 3'd0, 1'b1)}, shift: 3'd0};
    vecs[2] = '{src: 64'h0, dst: 64'h0, nbytes: 64'd2048, nr: 2'd1, nw: 2'd1,
                r: {exp_b_t'('0), mkb(64'h0, 8'd255, 3'd0, 3'd0, 1'b1)},
                w: {exp_b_t'('0), mkb(64'h0, 8'd255, 3'd0, 3'd0, 1'b1)}, shift: 3'd0};
    vecs[3] = '{src: 64'h0, dst: 64'h0, nbytes: 64'd4096, nr: 2'd2, nw: 2'd2,
                r: {mkb(64'h800, 8'd255, 3'd0, 3'd0, 1'b1), mkb(64'h0, 8'd255, 3'd0, 3'd0, 1'b0)},
                w: {mkb(64'h800, 8'd255, 3'd0, 3'd0, 1'b1), mkb(64'h0, 8'd255, 3'd0, 3'd0, 1'b0)},
                shift: 3'd0};
    vecs[4] = '{src: 64'h3, dst: 64'h5, nbytes: 64'd10, nr: 2'd1, nw: 2'd1,
                r: {exp_b_t'('0), mkb(64'h3, 8'd1, 3'd3, 3'd5, 1'b1)},
                w: {exp_b_t'('0), mkb(64'h5, 8'd1, 3'd5, 3'd7, 1'b1)}, shift: 3'd6};
    vecs[5] = '{src: 64'h0FFD, dst: 64'h10, nbytes: 64'd6, nr: 2'd2, nw: 2'd1,
                r: {mkb(64'h1000, 8'd0, 3'd0, 3'd3, 1'b1), mkb(64'h0FFD, 8'd0, 3'd5, 3'd0, 1'b0)},
                w: {exp_b_t'('0), mkb(64'h10, 8'd0, 3'd0, 3'd6, 1'b1)}, shift: 3'd5};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset r_valid", r_valid_o, 64'd0);
    chk("reset w_valid", w_valid_o, 64'd0);
    chk("reset ready", ready_o, 64'd1);
    chk("reset idle", idle_o, 64'd1);
    chk("reset read payload zero", 64'(|read_req_o), 64'd0);
    chk("reset write payload zero", 64'(|write_req_o), 64'd0);
    rst_i = 1'b0;

    for (int v = 0; v < NumVec; v++) run_vec(v, vecs[v]);

    // Backpressure on R for 5 cycles: R holds, W drains, ready stays low
    @(negedge clk);
    r_ready_i = 1'b0;
    send(64'h0, 64'h0, 64'd4096, 6'd9, 4'd1, 4'd2);
    chk("bp r valid", r_valid_o, 64'd1);
    chk("bp w0 valid", w_valid_o, 64'd1);
    chk("bp w0 addr", write_req_o.aw.addr, 64'h0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp c%0d r valid held", c), r_valid_o, 64'd1);
      chk($sformatf("bp c%0d r addr held", c), read_req_o.ar.addr, 64'h0);
      chk($sformatf("bp c%0d r len held", c), read_req_o.ar.len, 64'd255);
      chk($sformatf("bp c%0d r last held", c), read_req_o.ar.last, 64'd0);
      chk($sformatf("bp c%0d ready low", c), ready_o, 64'd0);
      if (c == 1) begin
        chk("bp w1 valid", w_valid_o, 64'd1);
        chk("bp w1 addr", write_req_o.aw.addr, 64'h800);
        chk("bp w1 last", write_req_o.aw.last, 64'd1);
      end else begin
        chk($sformatf("bp c%0d w drained", c), w_valid_o, 64'd0);
      end
    end
    r_ready_i = 1'b1;
    @(negedge clk);
    chk("bp r1 valid", r_valid_o, 64'd1);
    chk("bp r1 addr", read_req_o.ar.addr, 64'h800);
    chk("bp r1 last", read_req_o.ar.last, 64'd1);
    chk("bp ready before r last", ready_o, 64'd0);
    @(negedge clk);
    chk("bp r done", r_valid_o, 64'd0);
    chk("bp ready after r last", ready_o, 64'd1);

    // Zero-length transfer is consumed silently
    send(64'h40, 64'h80, 64'd0, 6'd3, 4'd0, 4'd0);
    chk("zero r_valid", r_valid_o, 64'd0);
    chk("zero w_valid", w_valid_o, 64'd0);
    chk("zero ready", ready_o, 64'd1);
    chk("zero idle", idle_o, 64'd1);

    // Asynchronous reset during BUSY
    r_ready_i = 1'b0;
    w_ready_i = 1'b0;
    send(64'h100, 64'h200, 64'd64, 6'd4, 4'd0, 4'd0);
    chk("rst pre r_valid", r_valid_o, 64'd1);
    chk("rst pre idle", idle_o, 64'd0);
    #2 rst_i = 1'b1;
    #1;
    chk("rst async r_valid", r_valid_o, 64'd0);
    chk("rst async w_valid", w_valid_o, 64'd0);
    chk("rst async idle", idle_o, 64'd1);
    chk("rst async ready", ready_o, 64'd1);
    @(negedge clk);
    rst_i = 1'b0;
    r_ready_i = 1'b1;
    w_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst post c%0d no valid", c), 64'(r_valid_o | w_valid_o), 64'd0);
    end
    run_vec(4, vecs[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
